vscpu_gen2: RTL and testbench
=============================

VSCPU_GEN2 -- requirements
Module: vscpu_gen2

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, memory word and datapath width.
REQ-002 SHALL provide parameter ADDR_LEN, default 14, word address width; legal only if DATA_W >= 4+2*ADDR_LEN.
REQ-003 SHALL provide port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL provide port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL provide port data_fromRAM  input  DATA_W  read data, valid in any cycle where mem_ack=1 for a read.
REQ-006 SHALL provide port mem_ack  input  1  RAM accepts the current request this cycle.
REQ-007 SHALL provide port mem_req  output  1  request valid; addr_toRAM/wrEn/data_toRAM meaningful.
REQ-008 SHALL provide port wrEn  output  1  request is a write.
REQ-009 SHALL provide port addr_toRAM  output  ADDR_LEN  request word address.
REQ-010 SHALL provide port data_toRAM  output  DATA_W  write data; 0 when not writing.
REQ-011 SHALL provide port pCounter  output  ADDR_LEN  program counter.
REQ-012 SHALL provide port instr_done  output  1  one-cycle pulse when an instruction retires.

Function
REQ-013 Instruction word SHALL be opcode=[DATA_W-1:DATA_W-4], A=[2*ADDR_LEN-1:ADDR_LEN], B=[ADDR_LEN-1:0]; immediates B zero-extended to DATA_W.
REQ-014 Handshake: request SHALL be transferred in a cycle with mem_req=1 and mem_ack=1; mem_req, wrEn, addr_toRAM, data_toRAM SHALL stay stable until then; FSM SHALL not advance while mem_ack=0.
REQ-015 FSM states SHALL be FETCH, RD_A, RD_B, RD_IND, WRITE; every instruction starts in FETCH (read at pCounter).
REQ-016 Transitions: FETCH->RD_A for all opcodes except CPi (FETCH->WRITE); RD_A->RD_B for two-operand register forms, CPI, CPIi, BZJ; RD_A->WRITE for immediate ALU forms; RD_A->FETCH for BZJi; RD_B->RD_IND for CPI; RD_B->WRITE for others except BZJ (RD_B->FETCH); RD_IND->WRITE; WRITE->FETCH.
REQ-017 Opcodes: 0/1 ADD(i) *A=*A+X; 2/3 NAND(i) *A=~(*A&X); 4/5 SRL(i) *A = X<DATA_W ? *A>>X : *A<<(X-DATA_W); 6/7 LT(i) *A=(*A<X) unsigned ?1:0; 8/9 CP(i) *A=X; 10 CPI *A=*(*B); 11 CPIi *(*A)=*B; 12 BZJ; 13 BZJi; 14/15 MUL(i) *A=low DATA_W bits of *A*X; X=*B or B.
REQ-018 Arithmetic SHALL wrap modulo 2^DATA_W; no flags.
REQ-019 Addresses derived from data (*A, *B) SHALL use the low ADDR_LEN bits.
REQ-020 BZJ: pCounter SHALL become *A if *B==0, else pCounter+1.
REQ-021 BZJi: pCounter SHALL become (*A+B) mod 2^ADDR_LEN.
REQ-022 All non-branch instructions SHALL set pCounter=pCounter+1, wrapping from 2^ADDR_LEN-1 to 0.
REQ-023 instr_done SHALL pulse in the cycle pCounter updates; with mem_ack tied 1, ADD SHALL retire in 4 cycles, CPi 2, BZJi 2, CPI 5.
REQ-024 A write whose target equals the instruction's own address SHALL take effect; the next fetch SHALL see the new word.

Reset
REQ-025 rst=1 SHALL immediately force state=FETCH, pCounter=0, internal registers 0, mem_req=0, wrEn=0, addr_toRAM=0, data_toRAM=0, instr_done=0, independent of clk.
REQ-026 Reset mid-request SHALL abandon it without a write transfer; after rst falls, first request SHALL be a fetch of address 0 on the next rising edge.

Configuration
REQ-027 Macro VSCPU_GEN2_MUL_EN defined: opcodes 14/15 SHALL execute MUL/MULi per REQ-017.
REQ-028 Macro undefined: opcodes 14/15 SHALL be NOPs (FETCH only, pCounter+1, no write, instr_done pulse), and no multiplier SHALL be synthesised.

Verification
REQ-029 mem_ack=1, mem[0]=ADD 100,101, mem[100]=7, mem[101]=5 -> write 12 to 100, pCounter=1, instr_done at cycle 4.
REQ-030 mem_ack low 3 cycles per request, same program -> identical result, request signals stable while stalled, retire at cycle 16.
REQ-031 DATA_W=32: SRLi *A=0x80000000, B=4 -> 0x08000000; SRLi *A=1, B=33 -> 0x00000002; LTi *A=3, B=3 -> 0.
REQ-032 BZJ *A=50, *B=0 -> pCounter=50; *B=1 -> pCounter+1; BZJi *A=2^14-1, B=2 -> pCounter=1.
REQ-033 CPI *B=200, mem[200]=0xDEAD -> *A=0xDEAD; CPIi *A=300, *B=9 -> mem[300]=9.
REQ-034 rst asserted in WRITE with mem_ack=0 -> no write, outputs 0 at once; with/without VSCPU_GEN2_MUL_EN, MULi *A=6, B=7 -> 42 / unchanged.

Source files
------------

// File: rtl/vscpu_gen2.sv
// vscpu_gen2 -- very small multi-cycle CPU with a single request/acknowledge
// memory port.
//
// Every instruction starts with a fetch at pCounter. Its operands are then read
// one memory word at a time, and at most one result word is written back.
//
// Instruction word:
//   [DATA_W-1 -: 4]            opcode
//   [2*ADDR_LEN-1 : ADDR_LEN]  A (word address)
//   [ADDR_LEN-1 : 0]           B (word address, or zero-extended immediate)
//
// Parameters:
//   DATA_W    memory word / datapath width (default 32)
//   ADDR_LEN  word address width (default 14); needs DATA_W >= 4+2*ADDR_LEN
//
// Ports:
//   clk           clock; all state changes on its rising edge
//   rst           asynchronous active-high reset
//   data_fromRAM  read data; valid in any cycle where mem_ack=1 for a read
//   mem_ack       RAM accepts the current request this cycle
//   mem_req       request valid
//   wrEn          request is a write
//   addr_toRAM    request word address
//   data_toRAM    write data; 0 when not writing
//   pCounter      program counter
//   instr_done    one-cycle pulse when an instruction retires
//
// Handshake: a request (mem_req, wrEn, addr_toRAM, data_toRAM) is transferred
// in a cycle where mem_req=1 and mem_ack=1. Until then all four request signals
// hold their values and the FSM does not advance. Every output is a register.
//
// Build option: define VSCPU_GEN2_MUL_EN to make opcodes 14/15 execute
// MUL/MULi. Without it they are one-fetch NOPs and no multiplier is built.

module vscpu_gen2 #(
  parameter int DATA_W   = 32,
  parameter int ADDR_LEN = 14
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   data_fromRAM,
  input  logic                mem_ack,
  output logic                mem_req,
  output logic                wrEn,
  output logic [ADDR_LEN-1:0] addr_toRAM,
  output logic [DATA_W-1:0]   data_toRAM,
  output logic [ADDR_LEN-1:0] pCounter,
  output logic                instr_done
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    RD_A   = 3'd1,
    RD_B   = 3'd2,
    RD_IND = 3'd3,
    WRITE  = 3'd4
  } state_t;

  localparam logic [3:0] OP_CPIMM = 4'd9;   // CPi  *A = B
  localparam logic [3:0] OP_CPI   = 4'd10;  // CPI  *A = *(*B)
  localparam logic [3:0] OP_CPII  = 4'd11;  // CPIi *(*A) = *B
  localparam logic [3:0] OP_BZJ   = 4'd12;
  localparam logic [3:0] OP_BZJI  = 4'd13;

  localparam logic [DATA_W-1:0]   DW    = DATA_W'(DATA_W);
  localparam logic [ADDR_LEN-1:0] A_ONE = ADDR_LEN'(1);

  state_t              state;
  logic [3:0]          op_r;   // opcode of the instruction in flight
  logic [ADDR_LEN-1:0] fa_r;   // A field
  logic [ADDR_LEN-1:0] fb_r;   // B field
  logic [DATA_W-1:0]   va_r;   // *A, read in RD_A

  // Fields of the word currently on the read bus (used in FETCH).
  logic [3:0]          d_op;
  logic [ADDR_LEN-1:0] d_a;
  logic [ADDR_LEN-1:0] d_b;
  logic [ADDR_LEN-1:0] d_low;
  logic [ADDR_LEN-1:0] pc_inc;

  assign d_op   = data_fromRAM[DATA_W-1 -: 4];
  assign d_a    = data_fromRAM[2*ADDR_LEN-1 -: ADDR_LEN];
  assign d_b    = data_fromRAM[ADDR_LEN-1:0];
  assign d_low  = data_fromRAM[ADDR_LEN-1:0];
  assign pc_inc = pCounter + A_ONE;

  function automatic logic [DATA_W-1:0] zext(input logic [ADDR_LEN-1:0] v);
    return {{(DATA_W-ADDR_LEN){1'b0}}, v};
  endfunction

  // Immediate ALU forms are the odd opcodes of the ALU group: 1,3,5,7 and 15.
  function automatic logic is_imm_alu(input logic [3:0] op);
    return op[0] && (!op[3] || (op[3:1] == 3'b111));
  endfunction

  function automatic logic is_nop(input logic [3:0] op);
`ifdef VSCPU_GEN2_MUL_EN
    return op != op;
`else
    return op[3:1] == 3'b111;
`endif
  endfunction

  // fn is opcode[3:1]; a register form and its immediate form share one fn.
  function automatic logic [DATA_W-1:0] alu(input logic [2:0]        fn,
                                            input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] r;
    r = x;
    case (fn)
      3'd0: r = a + x;
      3'd1: r = ~(a & x);
      // Shift amounts of DATA_W and above turn the right shift into a left
      // shift by the excess.
      3'd2: r = (x < DW) ? (a >> x) : (a << (x - DW));
      3'd3: r = (a < x) ? DATA_W'(1) : '0;
`ifdef VSCPU_GEN2_MUL_EN
      3'd7: r = a * x;
`endif
      default: r = x;  // CP: copy
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FETCH;
      pCounter   <= '0;
      op_r       <= '0;
      fa_r       <= '0;
      fb_r       <= '0;
      va_r       <= '0;
      mem_req    <= 1'b0;
      wrEn       <= 1'b0;
      addr_toRAM <= '0;
      data_toRAM <= '0;
      instr_done <= 1'b0;
    end else begin
      instr_done <= 1'b0;
      if (!mem_req) begin
        // Only seen right after reset: issue the first fetch at pCounter.
        mem_req    <= 1'b1;
        wrEn       <= 1'b0;
        addr_toRAM <= pCounter;
        data_toRAM <= '0;
        state      <= FETCH;
      end else if (mem_ack) begin
        case (state)
          FETCH: begin
            op_r <= d_op;
            fa_r <= d_a;
            fb_r <= d_b;
            if (d_op == OP_CPIMM) begin
              state      <= WRITE;
              wrEn       <= 1'b1;
              addr_toRAM <= d_a;
              data_toRAM <= zext(d_b);
            end else if (is_nop(d_op)) begin
              pCounter   <= pc_inc;
              addr_toRAM <= pc_inc;
              instr_done <= 1'b1;
            end else begin
              state      <= RD_A;
              addr_toRAM <= d_a;
            end
          end
          RD_A: begin
            va_r <= data_fromRAM;
            if (op_r == OP_BZJI) begin
              pCounter   <= d_low + fb_r;
              addr_toRAM <= d_low + fb_r;
              instr_done <= 1'b1;
              state      <= FETCH;
            end else if (is_imm_alu(op_r)) begin
              state      <= WRITE;
              wrEn       <= 1'b1;
              addr_toRAM <= fa_r;
              data_toRAM <= alu(op_r[3:1], data_fromRAM, zext(fb_r));
            end else begin
              state      <= RD_B;
              addr_toRAM <= fb_r;
            end
          end
          RD_B: begin
            case (op_r)
              OP_CPI: begin
                state      <= RD_IND;
                addr_toRAM <= d_low;
              end
              OP_CPII: begin
                state      <= WRITE;
                wrEn       <= 1'b1;
                addr_toRAM <= va_r[ADDR_LEN-1:0];
                data_toRAM <= data_fromRAM;
              end
              OP_BZJ: begin
                pCounter   <= (data_fromRAM == '0) ? va_r[ADDR_LEN-1:0] : pc_inc;
                addr_toRAM <= (data_fromRAM == '0) ? va_r[ADDR_LEN-1:0] : pc_inc;
                instr_done <= 1'b1;
                state      <= FETCH;
              end
              default: begin
                state      <= WRITE;
                wrEn       <= 1'b1;
                addr_toRAM <= fa_r;
                data_toRAM <= alu(op_r[3:1], va_r, data_fromRAM);
              end
            endcase
          end
          RD_IND: begin
            state      <= WRITE;
            wrEn       <= 1'b1;
            addr_toRAM <= fa_r;
            data_toRAM <= data_fromRAM;
          end
          WRITE: begin
            pCounter   <= pc_inc;
            addr_toRAM <= pc_inc;
            wrEn       <= 1'b0;
            data_toRAM <= '0;
            instr_done <= 1'b1;
            state      <= FETCH;
          end
          default: begin
            state      <= FETCH;
            wrEn       <= 1'b0;
            data_toRAM <= '0;
            addr_toRAM <= pCounter;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vscpu_gen2.sv
// Self-checking bench for vscpu_gen2 (DATA_W=32, ADDR_LEN=14).
// The RAM model answers requests with a programmable number of wait cycles.
// An instruction-level reference model executes the same program on its own
// copy of memory. pCounter is compared at every retirement, and memory is
// compared after each program.
module tb_vscpu_gen2;
  localparam int W = 32;
  localparam int AL = 14;
  localparam int MSZ = 16384;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  data_fromRAM = '0;
  logic          mem_ack = 1'b0;
  logic          mem_req, wrEn, instr_done;
  logic [AL-1:0] addr_toRAM, pCounter;
  logic [W-1:0]  data_toRAM;

  vscpu_gen2 #(.DATA_W(W), .ADDR_LEN(AL)) dut (
    .clk(clk), .rst(rst), .data_fromRAM(data_fromRAM), .mem_ack(mem_ack),
    .mem_req(mem_req), .wrEn(wrEn), .addr_toRAM(addr_toRAM),
    .data_toRAM(data_toRAM), .pCounter(pCounter), .instr_done(instr_done)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] mem [MSZ];   // RAM seen by the DUT
  logic [W-1:0] mm  [MSZ];   // reference model memory
  int mpc = 0;               // reference model program counter
  logic [AL-1:0] exp_q[$];   // expected pCounter after each retirement
  int lat_q[$];              // cycles per retired instruction

  int stall_fixed = 0;       // >=0: fixed wait cycles per request, -1: random
  int stall_max = 0;
  bit block_writes = 0;      // withhold mem_ack from write requests
  int wait_cnt = 0;
  int cur_lim = 0;
  bit st_valid = 0;
  logic [1+1+AL+W-1:0] st_saved = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- RAM model ----------------
  always @(posedge clk) begin
    if (rst) begin
      wait_cnt = 0;
      cur_lim = (stall_fixed >= 0) ? stall_fixed : int'($urandom_range(0, stall_max));
    end else if (mem_req && mem_ack) begin
      if (wrEn) mem[addr_toRAM] = data_toRAM;
      wait_cnt = 0;
      cur_lim = (stall_fixed >= 0) ? stall_fixed : int'($urandom_range(0, stall_max));
    end else if (mem_req) begin
      wait_cnt++;
    end
  end

  always @(negedge clk) begin
    // A request that was stalled at the previous sample must still be unchanged.
    if (st_valid && !rst)
      chk("req_stable", {mem_req, wrEn, addr_toRAM, data_toRAM}, st_saved);
    mem_ack = mem_req && (wait_cnt >= cur_lim) && !(block_writes && wrEn);
    data_fromRAM = mem[addr_toRAM];
    st_valid = mem_req && !mem_ack && !rst;
    st_saved = {mem_req, wrEn, addr_toRAM, data_toRAM};
  end

  // ---------------- helpers / driver tasks ----------------
  function automatic logic [W-1:0] ins(input int op, input int a, input int b);
    return (32'(op) << 28) | (32'(a) << 14) | 32'(b);
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < MSZ; i++) begin mem[i] = '0; mm[i] = '0; end
  endtask

  task automatic set(input int addr, input logic [W-1:0] v);
    mem[addr] = v;
    mm[addr] = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    st_valid = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mpc = 0;
  endtask

  // Executes one instruction of the reference model straight from the ISA rules.
  task automatic model_step();
    logic [W-1:0] w, va, x, r;
    int op, a, b, wa, npc;
    bit wr;
    w = mm[mpc];
    op = int'(w[31:28]);
    a = int'(w[27:14]);
    b = int'(w[13:0]);
    va = mm[a];
    x = (op % 2 == 1) ? 32'(b) : mm[b];
    wr = 1;
    wa = a;
    npc = (mpc + 1) % MSZ;
    r = '0;
    case (op)
      0, 1: r = va + x;
      2, 3: r = ~(va & x);
      4, 5: begin
        if (x < 32) r = va >> x;
        else if (x - 32 < 32) r = va << (x - 32);
        else r = '0;
      end
      6, 7: r = (va < x) ? 32'd1 : 32'd0;
      8, 9: r = x;
      10: r = mm[int'(mm[b] % MSZ)];
      11: begin wa = int'(va % MSZ); r = mm[b]; end
      12: begin wr = 0; if (mm[b] == 0) npc = int'(va % MSZ); end
      13: begin wr = 0; npc = int'((va + 32'(b)) % MSZ); end
      default: begin
`ifdef VSCPU_GEN2_MUL_EN
        r = va * x;
`else
        wr = 0;
`endif
      end
    endcase
    if (wr) mm[wa] = r;
    mpc = npc;
  endtask

  // Runs n instructions after reset release, checking pCounter at each
  // retirement; the cycle budget bounds the wait.
  task automatic run(input string tag, input int n, input int budget);
    int cyc, done, last;
    logic [AL-1:0] e;
    cyc = 0; done = 0; last = 1;
    lat_q.delete();
    while (done < n && cyc < budget) begin
      @(posedge clk);
      #1;
      cyc++;
      if (instr_done === 1'b1) begin
        model_step();
        exp_q.push_back(AL'(mpc));
        e = exp_q.pop_front();
        chk($sformatf("%s_pc%0d", tag, done), pCounter, e);
        lat_q.push_back(cyc - last);
        last = cyc;
        done++;
      end
    end
    chk({tag, "_retired"}, done, n);
  endtask

  task automatic compare_mem(input string tag);
    int bad, first;
    bad = 0; first = -1;
    for (int i = 0; i < MSZ; i++)
      if (mem[i] !== mm[i]) begin bad++; if (first < 0) first = i; end
    if (bad != 0) $display("memory differs first at word %0d", first);
    chk({tag, "_mem"}, bad, 0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int k, op, b;
    clear_mem();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_wrEn", wrEn, 0);
    chk("rst_addr", addr_toRAM, 0);
    chk("rst_data", data_toRAM, 0);
    chk("rst_pc", pCounter, 0);
    chk("rst_done", instr_done, 0);

    // ADD 100,101 with no wait states
    clear_mem();
    set(0, ins(0, 100, 101)); set(100, 7); set(101, 5);
    stall_fixed = 0; do_reset();
    run("add", 1, 50);
    chk("add_result", mem[100], 12);
    chk("add_pc", pCounter, 1);
    chk("add_lat", lat_q.size() > 0 ? lat_q[0] : -1, 4);
    compare_mem("add");

    // Same program, three wait cycles on every request
    clear_mem();
    set(0, ins(0, 100, 101)); set(100, 7); set(101, 5);
    stall_fixed = 3; do_reset();
    run("add_stall", 1, 100);
    chk("add_stall_result", mem[100], 12);
    chk("add_stall_lat", lat_q.size() > 0 ? lat_q[0] : -1, 16);

    // Shifts across the DATA_W boundary, LTi equality, CPi timing
    clear_mem();
    set(0, ins(5, 100, 4)); set(1, ins(5, 101, 33));
    set(2, ins(7, 102, 3)); set(3, ins(9, 103, 5));
    set(100, 32'h8000_0000); set(101, 1); set(102, 3);
    stall_fixed = 0; do_reset();
    run("alu", 4, 100);
    chk("srli_4", mem[100], 32'h0800_0000);
    chk("srli_33", mem[101], 32'h0000_0002);
    chk("lti_eq", mem[102], 0);
    chk("cpi_imm", mem[103], 5);
    chk("cpi_imm_lat", lat_q.size() > 3 ? lat_q[3] : -1, 2);
    compare_mem("alu");

    // Branches: taken BZJ, not-taken BZJ, BZJi wrapping past the top address
    clear_mem();
    set(0, ins(12, 100, 101)); set(50, ins(12, 100, 102)); set(51, ins(13, 103, 2));
    set(100, 50); set(101, 0); set(102, 1); set(103, 32'h3FFF);
    stall_fixed = 0; do_reset();
    run("br", 3, 100);
    chk("bzji_pc", pCounter, 1);
    chk("bzji_lat", lat_q.size() > 2 ? lat_q[2] : -1, 2);

    // Indirect copies
    clear_mem();
    set(0, ins(10, 100, 101)); set(1, ins(11, 102, 103));
    set(101, 200); set(200, 32'hDEAD); set(102, 300); set(103, 9);
    stall_fixed = 0; do_reset();
    run("ind", 2, 100);
    chk("cpi_ind", mem[100], 32'hDEAD);
    chk("cpii_ind", mem[300], 9);
    chk("cpi_ind_lat", lat_q.size() > 0 ? lat_q[0] : -1, 5);
    compare_mem("ind");

    // An instruction overwrites its own word; the refetch executes the new word
    clear_mem();
    set(0, ins(8, 0, 20)); set(1, ins(13, 21, 0)); set(20, ins(9, 30, 77));
    stall_fixed = 1; do_reset();
    run("selfmod", 3, 200);
    chk("selfmod_word", mem[0], ins(9, 30, 77));
    chk("selfmod_exec", mem[30], 77);

    // MULi 6*7: 42 with the multiplier built in, else a NOP
    clear_mem();
    set(0, ins(15, 100, 7)); set(100, 6);
    stall_fixed = 0; do_reset();
    run("muli", 1, 50);
`ifdef VSCPU_GEN2_MUL_EN
    chk("muli_result", mem[100], 42);
`else
    chk("muli_result", mem[100], 6);
    chk("muli_nop_lat", lat_q.size() > 0 ? lat_q[0] : -1, 1);
`endif
    chk("muli_pc", pCounter, 1);

    // Reset during a stalled write: the write is dropped, outputs clear at once
    clear_mem();
    set(0, ins(9, 40, 9)); set(40, 32'h1234);
    stall_fixed = 0; block_writes = 1; do_reset();
    k = 0;
    while (wrEn !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    chk("rstmid_in_write", wrEn, 1);
    #2;
    rst = 1'b1;
    st_valid = 0;
    #1;
    chk("rstmid_mem_req", mem_req, 0);
    chk("rstmid_wrEn", wrEn, 0);
    chk("rstmid_addr", addr_toRAM, 0);
    chk("rstmid_data", data_toRAM, 0);
    chk("rstmid_pc", pCounter, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    block_writes = 0;
    chk("rstmid_no_write", mem[40], 32'h1234);
    @(posedge clk);
    #1;
    chk("rstmid_fetch_req", mem_req, 1);
    chk("rstmid_fetch_wr", wrEn, 0);
    chk("rstmid_fetch_addr", addr_toRAM, 0);

    // Random programs with random wait states
    for (int p = 0; p < 6; p++) begin
      clear_mem();
      for (int i = 0; i < 64; i++) begin
        op = int'($urandom_range(0, 15));
        b = (op % 2 == 1 && op != 11) ? int'($urandom_range(0, 40)) : int'($urandom_range(64, 79));
        set(i, ins(op, int'($urandom_range(64, 79)), b));
      end
      for (int i = 64; i < 80; i++)
        set(i, ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 63)));
      stall_fixed = -1; stall_max = p % 4;
      do_reset();
      run($sformatf("rand%0d", p), 40, 4000);
      compare_mem($sformatf("rand%0d", p));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
